// File: rtl/reel_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : reel_sequencer_if
// Description : Game-FSM side bundle of the reel sequencer (spin enables,
//               end-of-game messages, reel letters and round-done pulse).
// Revision    : 1.0 - initial release
// ============================================================================
interface reel_sequencer_if;
   logic [3:0] run;
   logic       end_flag;
   logic [4:0] message0;
   logic [4:0] message1;
   logic [4:0] message2;
   logic [4:0] message3;
   logic [3:0] letter0;
   logic [3:0] letter1;
   logic [3:0] letter2;
   logic [3:0] letter3;
   logic       round_done;

   modport master (
      output run, end_flag, message0, message1, message2, message3,
      input  letter0, letter1, letter2, letter3, round_done
   );

   modport slave (
      input  run, end_flag, message0, message1, message2, message3,
      output letter0, letter1, letter2, letter3, round_done
   );
endinterface
`default_nettype wire

// File: rtl/reel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reel_sequencer
// Description : Four reel letter registers stepped by one shared incrementer,
//               plus a 4-digit display scanner. Optional macro
//               REEL_LFSR_STEP_EN adds an LFSR-randomised step of 1 or 2.
// Revision    : 1.0 - initial release
// ============================================================================
module reel_sequencer #(
   parameter int CLK_DIV     = 5_000_000,
   parameter int NUM_LETTERS = 10,
   parameter int SCAN_DIV    = 50_000
) (
   input  logic             clk,
   input  logic             reset,
   reel_sequencer_if.slave  bus,
   output logic [3:0]       digit_sel,
   output logic [4:0]       digit_code
);

   localparam int c_PW = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
   localparam int c_SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_PW-1:0] c_PMAX = c_PW'(CLK_DIV - 1);
   localparam logic [c_SW-1:0] c_SMAX = c_SW'(SCAN_DIV - 1);
   localparam logic [4:0]      c_NL   = 5'(NUM_LETTERS);

   logic [c_PW-1:0] r_presc;
   logic [1:0]      r_ptr;
   logic [3:0]      r_letter [4];
   logic [3:0]      r_run_q;
   logic            r_round_done;
   logic [c_SW-1:0] r_scan;
   logic [1:0]      r_idx;
   logic [3:0]      r_digit_sel;
   logic [4:0]      r_digit_code;

   logic            w_tick;
   logic            w_scan_wrap;
   logic [4:0]      w_delta;
   logic [4:0]      w_sum;
   logic [3:0]      w_next;
   logic [4:0]      w_msg [4];

   assign w_tick      = (r_presc == c_PMAX);
   assign w_scan_wrap = (r_scan == c_SMAX);

`ifdef REEL_LFSR_STEP_EN
   logic [7:0] r_lfsr;

   // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lfsr <= 8'hA5;
      end else begin
         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      end
   end

   assign w_delta = 5'd1 + {4'd0, r_lfsr[0]};
`else
   assign w_delta = 5'd1;
`endif

   // Shared incrementer: delta is at most 2 so one conditional subtract wraps it
   assign w_sum = {1'b0, r_letter[r_ptr]} + w_delta;

   always_comb begin
      w_next = w_sum[3:0];
      if (w_sum >= c_NL) begin
         w_next = 4'(w_sum - c_NL);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
         r_ptr   <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            r_letter[i] <= 4'd0;
         end
      end else begin
         r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
         if (w_tick) begin
            if (bus.run[r_ptr]) begin
               r_letter[r_ptr] <= w_next;
            end
            r_ptr <= r_ptr + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_run_q      <= 4'd0;
         r_round_done <= 1'b0;
      end else begin
         r_run_q      <= bus.run;
         r_round_done <= (r_run_q != 4'd0) && (bus.run == 4'd0);
      end
   end

   assign w_msg[0] = bus.message0;
   assign w_msg[1] = bus.message1;
   assign w_msg[2] = bus.message2;
   assign w_msg[3] = bus.message3;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scan       <= '0;
         r_idx        <= 2'd0;
         r_digit_sel  <= 4'b0001;
         r_digit_code <= 5'd0;
      end else begin
         r_scan <= w_scan_wrap ? '0 : r_scan + c_SW'(1);
         if (w_scan_wrap) begin
            r_idx <= r_idx + 2'd1;
         end
         r_digit_sel  <= 4'b0001 << r_idx;
         r_digit_code <= bus.end_flag ? w_msg[r_idx] : {1'b0, r_letter[r_idx]};
      end
   end

   assign bus.letter0    = r_letter[0];
   assign bus.letter1    = r_letter[1];
   assign bus.letter2    = r_letter[2];
   assign bus.letter3    = r_letter[3];
   assign bus.round_done = r_round_done;
   assign digit_sel      = r_digit_sel;
   assign digit_code     = r_digit_code;

endmodule
`default_nettype wire

// File: tb/tb_reel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reel_sequencer
// Description : Directed self-checking bench for reel_sequencer
//               (CLK_DIV=4, NUM_LETTERS=10, SCAN_DIV=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reel_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] digit_sel;
   logic [4:0] digit_code;
   int         total = 0;
   int         bad   = 0;

   reel_sequencer_if bus ();

   reel_sequencer #(
      .CLK_DIV     (4),
      .NUM_LETTERS (10),
      .SCAN_DIV    (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .digit_sel  (digit_sel),
      .digit_code (digit_code)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] letter(input int i);
      case (i)
         0:       return bus.letter0;
         1:       return bus.letter1;
         2:       return bus.letter2;
         default: return bus.letter3;
      endcase
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reset is released on a falling edge, so the prescaler sits at 0 there
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (letter(i) !== 4'd0) begin
            bad++; $display("FAIL reset_letter%0d: got %0d expected 0", i, letter(i));
         end
      end
      total++;
      if (bus.round_done !== 1'b0) begin
         bad++; $display("FAIL reset_round_done: got %0b expected 0", bus.round_done);
      end
      total++;
      if (digit_sel !== 4'b0001) begin
         bad++; $display("FAIL reset_digit_sel: got %b expected 0001", digit_sel);
      end
      total++;
      if (digit_code !== 5'd0) begin
         bad++; $display("FAIL reset_digit_code: got %h expected 00", digit_code);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_first_ticks();
      do_reset();
      bus.run = 4'hF;
      for (int k = 0; k < 4; k++) begin
         cycles(3);
         total++;
         if (letter(k) !== 4'd0) begin
            bad++; $display("FAIL first_pre%0d: got %0d expected 0", k, letter(k));
         end
         cycles(1);
         total++;
         if (letter(k) !== 4'd1) begin
            bad++; $display("FAIL first_step%0d: got %0d expected 1", k, letter(k));
         end
      end
      cycles(4);
      total++;
      if (bus.letter0 !== 4'd2) begin
         bad++; $display("FAIL ptr_wrap: got %0d expected 2", bus.letter0);
      end
   endtask

   task automatic test_wrap();
      int exp_l [4];
      int r;
      do_reset();
      bus.run = 4'hF;
      for (int i = 0; i < 4; i++) exp_l[i] = 0;
      for (int t = 1; t <= 40; t++) begin
         cycles(4);
         r = (t - 1) % 4;
         exp_l[r] = (exp_l[r] + 1) % 10;
         total++;
         if (letter(r) !== 4'(exp_l[r])) begin
            bad++; $display("FAIL wrap_tick%0d_reel%0d: got %0d expected %0d", t, r, letter(r), exp_l[r]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (letter(i) !== 4'd0) begin
            bad++; $display("FAIL wrap_end%0d: got %0d expected 0", i, letter(i));
         end
      end
   endtask

   task automatic test_skip();
      do_reset();
      bus.run = 4'hF;
      cycles(16);
      bus.run = 4'b1110;
      cycles(32);
      total++;
      if (bus.letter0 !== 4'd1) begin
         bad++; $display("FAIL skip_frozen: got %0d expected 1", bus.letter0);
      end
      for (int i = 1; i < 4; i++) begin
         total++;
         if (letter(i) !== 4'd3) begin
            bad++; $display("FAIL skip_adv%0d: got %0d expected 3", i, letter(i));
         end
      end
      bus.run = 4'hF;
      cycles(4);
      total++;
      if (bus.letter0 !== 4'd2) begin
         bad++; $display("FAIL skip_resume: got %0d expected 2", bus.letter0);
      end
   endtask

   task automatic test_round_done();
      int pulses;
      do_reset();
      bus.run = 4'b0001;
      cycles(2);
      total++;
      if (bus.round_done !== 1'b0) begin
         bad++; $display("FAIL rd_idle: got %0b expected 0", bus.round_done);
      end
      bus.run = 4'b0000;
      cycles(1);
      total++;
      if (bus.round_done !== 1'b1) begin
         bad++; $display("FAIL rd_pulse: got %0b expected 1", bus.round_done);
      end
      cycles(1);
      total++;
      if (bus.round_done !== 1'b0) begin
         bad++; $display("FAIL rd_one_cycle: got %0b expected 0", bus.round_done);
      end
      pulses = 0;
      for (int k = 0; k < 100; k++) begin
         cycles(1);
         if (bus.round_done === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++; $display("FAIL rd_held: got %0d pulses expected 0", pulses);
      end
      bus.run = 4'hF;
      cycles(1);
      bus.run = 4'h0;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         cycles(1);
         if (bus.round_done === 1'b1) pulses++;
      end
      total++;
      if (pulses != 1) begin
         bad++; $display("FAIL rd_second: got %0d pulses expected 1", pulses);
      end
   endtask

   task automatic sync_digit0(output bit found);
      logic [3:0] prev;
      found = 1'b0;
      prev  = digit_sel;
      for (int k = 0; k < 16; k++) begin
         cycles(1);
         if (prev == 4'b1000 && digit_sel == 4'b0001) begin
            found = 1'b1;
            break;
         end
         prev = digit_sel;
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL scan_sync: digit0 not seen after digit3 within 16 cycles");
      end
   endtask

   task automatic test_display();
      int tgt [4];
      logic [3:0] mask;
      bit found;
      tgt[0] = 3; tgt[1] = 5; tgt[2] = 7; tgt[3] = 9;
      do_reset();
      for (int r = 0; r < 9; r++) begin
         for (int i = 0; i < 4; i++) mask[i] = (r < tgt[i]);
         bus.run = mask;
         cycles(16);
      end
      bus.run = 4'h0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (letter(i) !== 4'(tgt[i])) begin
            bad++; $display("FAIL disp_setup%0d: got %0d expected %0d", i, letter(i), tgt[i]);
         end
      end
      sync_digit0(found);
      for (int d = 0; d < 4; d++) begin
         for (int h = 0; h < 2; h++) begin
            total++;
            if (digit_sel !== (4'b0001 << d) || digit_code !== 5'(tgt[d])) begin
               bad++; $display("FAIL scan_d%0d_h%0d: got sel=%b code=%h expected sel=%b code=%h",
                               d, h, digit_sel, digit_code, 4'b0001 << d, 5'(tgt[d]));
            end
            cycles(1);
         end
      end
      bus.end_flag = 1'b1;
      bus.message0 = 5'h10;
      bus.message1 = 5'h11;
      bus.message2 = 5'h12;
      bus.message3 = 5'h13;
      sync_digit0(found);
      total++;
      if (digit_sel !== 4'b0001 || digit_code !== 5'h10) begin
         bad++; $display("FAIL msg0: got sel=%b code=%h expected sel=0001 code=10", digit_sel, digit_code);
      end
      cycles(2);
      total++;
      if (digit_sel !== 4'b0010 || digit_code !== 5'h11) begin
         bad++; $display("FAIL msg1: got sel=%b code=%h expected sel=0010 code=11", digit_sel, digit_code);
      end
      bus.end_flag = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.run = 4'hF;
      cycles(15);
      total++;
      if (bus.letter0 !== 4'd1) begin
         bad++; $display("FAIL mid_pre: got %0d expected 1", bus.letter0);
      end
      // Prescaler is at CLK_DIV-1 here: reset lands inside a tick cycle
      reset = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (letter(i) !== 4'd0) begin
            bad++; $display("FAIL mid_letter%0d: got %0d expected 0", i, letter(i));
         end
      end
      total++;
      if (bus.round_done !== 1'b0 || digit_sel !== 4'b0001 || digit_code !== 5'd0) begin
         bad++; $display("FAIL mid_outputs: got rd=%0b sel=%b code=%h expected rd=0 sel=0001 code=00",
                         bus.round_done, digit_sel, digit_code);
      end
      @(negedge clk);
      reset = 1'b0;
      cycles(3);
      total++;
      if (bus.letter0 !== 4'd0) begin
         bad++; $display("FAIL mid_early: got %0d expected 0", bus.letter0);
      end
      cycles(1);
      total++;
      if (bus.letter0 !== 4'd1) begin
         bad++; $display("FAIL mid_first_tick: got %0d expected 1", bus.letter0);
      end
   endtask

`ifdef REEL_LFSR_STEP_EN
   task automatic test_lfsr();
      logic [7:0] lf;
      int exp_l [4];
      int r;
      do_reset();
      bus.run = 4'hF;
      lf = 8'hA5;
      r  = 0;
      for (int i = 0; i < 4; i++) exp_l[i] = 0;
      for (int c = 1; c <= 80; c++) begin
         if (c % 4 == 0) begin
            r = (c / 4 - 1) % 4;
            exp_l[r] = (exp_l[r] + 1 + int'(lf[0])) % 10;
         end
         lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
         cycles(1);
         if (c % 4 == 0) begin
            total++;
            if (letter(r) !== 4'(exp_l[r]) || letter(r) >= 4'd10) begin
               bad++; $display("FAIL lfsr_c%0d_reel%0d: got %0d expected %0d", c, r, letter(r), exp_l[r]);
            end
         end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset        = 1'b1;
      bus.run      = 4'h0;
      bus.end_flag = 1'b0;
      bus.message0 = 5'h00;
      bus.message1 = 5'h00;
      bus.message2 = 5'h00;
      bus.message3 = 5'h00;
      cycles(3);
      test_reset();
      test_round_done();
      test_reset_mid();
`ifdef REEL_LFSR_STEP_EN
      test_lfsr();
`else
      test_first_ticks();
      test_wrap();
      test_skip();
      test_display();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
